// File: rtl/rr_pkg.sv
// Shared definitions for the static-region side of the reconfigurable-region port.
package rr_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int CERR_CNT_W = 16;

  // Reconfiguration sequence: normal traffic, request to RM, isolated, RM reset.
  typedef enum logic [1:0] {
    RUN = 2'd0,
    REQ = 2'd1,
    ISO = 2'd2,
    RST = 2'd3
  } rr_state_e;

endpackage

// File: rtl/rr_sfifo.sv
// Synchronous first-word-fall-through FIFO holding RM results for the downstream sink.
// full/empty are registered; rd_data is the head entry whenever empty is low.
module rr_sfifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          wr_ok;
  logic          rd_ok;

  // A write into a full FIFO is legal when the head is leaving in the same cycle.
  assign wr_ok      = wr_en & (~full | rd_en);
  assign rd_ok      = rd_en & ~empty;
  assign count_next = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  assign rd_data    = mem[rd_ptr];

  // Storage array write port.
  // NOTE: the data array is deliberately not reset; pointers and flags define validity,
  // and leaving it unreset lets it map onto plain RAM/register cells without a reset net.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer, occupancy and flag registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/rr_static_port.sv
// Static-region endpoint of a reconfigurable region: feeds the RM consumer channel from
// upstream, buffers RM results for downstream, and sequences request/isolate/reset
// around partial-bitstream loading.
module rr_static_port
  import rr_pkg::*;
#(
  parameter int DW           = DW_DEFAULT,
  parameter int P_FIFO_DEPTH = 8,
  parameter int ACK_TIMEOUT  = 1024,
  parameter int RST_CYC      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW-1:0]         m_data,
  output logic                  rr_rstn,
  output logic                  rr_rc_reqn,
  input  logic                  rr_rc_ackn,
  output logic                  rr_c_prdy,
  input  logic                  rr_c_crdy,
  input  logic                  rr_c_cerr,
  output logic [DW-1:0]         rr_c_data,
  input  logic                  rr_p_prdy,
  output logic                  rr_p_crdy,
  output logic                  rr_p_cerr,
  input  logic [DW-1:0]         rr_p_data,
  input  logic                  reconf_req,
  output logic                  reconf_ready,
  input  logic                  reconf_done,
  output logic                  ack_timeout,
  output logic [CERR_CNT_W-1:0] cerr_cnt
);

  localparam int CNT_MAX = (ACK_TIMEOUT > RST_CYC) ? ACK_TIMEOUT : RST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  rr_state_e          state;
  rr_state_e          state_next;
  logic [CNT_W-1:0]   cnt;
  logic               timeout_hit;
  logic               link_up;
  logic               c_full;
  logic               c_fire;
  logic               c_ok;
  logic               c_rej;
  logic               s_fire;
  logic               fifo_full;
  logic               fifo_empty;
  logic               rr_rstn_q;

  // The RM channels are live only before isolation; in ISO/RST its outputs are ignored.
  assign link_up      = (state == RUN) || (state == REQ);

  assign rr_c_prdy    = c_full & link_up;
  assign c_fire       = rr_c_prdy & rr_c_crdy;
  assign c_ok         = c_fire & ~rr_c_cerr;
  assign c_rej        = c_fire & rr_c_cerr;
  assign s_ready      = (state == RUN) & (~c_full | c_ok);
  assign s_fire       = s_valid & s_ready;

  assign rr_p_crdy    = ~fifo_full & link_up;
  assign rr_p_cerr    = 1'b0;
  assign m_valid      = ~fifo_empty;

  assign rr_rc_reqn   = (state != REQ);
  assign reconf_ready = (state == ISO);
  assign rr_rstn      = rr_rstn_q;

  assign timeout_hit  = (state == REQ) && rr_rc_ackn && (cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Next-state decode for the reconfiguration sequence.
  // NOTE: state_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      RUN: if (reconf_req) state_next = REQ;
      REQ: if (!rr_rc_ackn || timeout_hit) state_next = ISO;
      ISO: if (reconf_done) state_next = RST;
      RST: if (cnt == CNT_W'(RST_CYC - 1)) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // State, shared dwell counter, sticky timeout flag and registered RM reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= RUN;
      cnt         <= '0;
      ack_timeout <= 1'b0;
      rr_rstn_q   <= 1'b0;
    end else begin
      state <= state_next;
      if ((state_next != state) || (state == RUN) || (state == ISO)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == RUN) && reconf_req) begin
        ack_timeout <= 1'b0;
      end else if (timeout_hit) begin
        ack_timeout <= 1'b1;
      end
      rr_rstn_q <= (state_next == RUN) || (state_next == REQ);
    end
  end

  // One-entry c-path holding register; a rejected or isolated beat stays put.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      c_full    <= 1'b0;
      rr_c_data <= '0;
    end else if (s_fire) begin
      c_full    <= 1'b1;
      rr_c_data <= s_data;
    end else if (c_ok) begin
      c_full    <= 1'b0;
    end
  end

  // Saturating count of beats the RM rejected.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cerr_cnt <= '0;
    end else if (c_rej && (cerr_cnt != '1)) begin
      cerr_cnt <= cerr_cnt + CERR_CNT_W'(1);
    end
  end

  rr_sfifo #(
    .DW    (DW),
    .DEPTH (P_FIFO_DEPTH)
  ) u_p_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (rr_p_prdy & rr_p_crdy),
    .wr_data (rr_p_data),
    .full    (fifo_full),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .empty   (fifo_empty)
  );

endmodule
